mc_control: RTL and testbench
=============================

Name: mc_control

Overview:
Main control state machine for the multi-cycle MIPS datapath. It is the initiator side of the ALU interface: it drives alu_ctr and consumes zero/overflow, and sequences PC, IR, register-file and data-memory enables. One instruction passes through the FETCH/DECODE/execute/writeback states. Outputs are Moore-decoded from the state register plus the latched op/funct.

Parameters:
RESET_STATE, 4'd0, state entered on reset (FETCH)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
op  input  6  instr[31:26] from IR, stable after FETCH
funct  input  6  instr[5:0] from IR
zero  input  1  ALU zero flag (valid for alu_ctr=01)
overflow  input  1  ALU overflow flag (valid for alu_ctr=11)
pc_wr  output  1  PC load enable
pc_src  output  2  00 ALU result (PC+4), 01 ALUOut reg (branch target), 10 jump target {PC[31:28],instr[25:0],2'b00}
ir_wr  output  1  IR load enable
mem_wr  output  1  data memory write enable
reg_wr  output  1  register file write enable
reg_dst  output  2  00 rt, 01 rd, 10 r31
mem_to_reg  output  2  00 ALUOut, 01 MDR, 10 sltout, 11 PC
alu_src_a  output  1  0 PC, 1 A reg
alu_src_b  output  2  00 B reg, 01 const 4, 10 ext imm, 11 ext imm<<2
ext_op  output  2  00 zero-ext, 01 sign-ext, 10 imm<<16
alu_ctr  output  2  00 add, 01 sub, 10 or, 11 overflow-checked add
illegal  output  1  one-cycle pulse on unsupported opcode/funct
state  output  4  current state, for debug

Behaviour:
- Reset (async, rst=1): state=FETCH. All enables are 0 while rst is high. After release, FETCH outputs apply from the first edge.
- Default for every output is 0 unless listed for a state.
- Decode table: R-type op=000000 with funct 100001 addu, 100011 subu, 101010 slt. I/J: 001101 ori, 001111 lui, 001000 addi, 100011 lw, 101011 sw, 000100 beq, 000010 j, 000011 jal.
- FETCH(0): ir_wr=1, pc_wr=1, pc_src=00, alu_src_a=0, alu_src_b=01, alu_ctr=00. -> DECODE.
- DECODE(1): alu_src_a=0, alu_src_b=11, ext_op=01, alu_ctr=00 (branch target into ALUOut).
  - lw/sw -> MEMADR. R-type legal -> EXE_R. ori/lui/addi -> EXE_I. beq -> BRANCH. j/jal -> JUMP.
  - Otherwise illegal=1 -> FETCH.
- MEMADR(2): alu_src_a=1, alu_src_b=10, ext_op=01, alu_ctr=00. lw -> MEMRD; sw -> MEMWR.
- MEMRD(3): read cycle, no enables. -> MEMWB.
- MEMWB(4): reg_wr=1, reg_dst=00, mem_to_reg=01. -> FETCH.
- MEMWR(5): mem_wr=1, alu_src_a=1, alu_src_b=10, ext_op=01. -> FETCH.
- EXE_R(6): alu_src_a=1, alu_src_b=00, alu_ctr=00 for addu, 01 for subu/slt. -> ALUWB.
- ALUWB(7): reg_wr=1, reg_dst=01, mem_to_reg=10 for slt else 00. Keeps EXE_R ALU controls. -> FETCH.
- BRANCH(8): alu_src_a=1, alu_src_b=00, alu_ctr=01, pc_src=01, pc_wr=zero (combinational). -> FETCH.
- JUMP(9): pc_wr=1, pc_src=10. For jal also reg_wr=1, reg_dst=10, mem_to_reg=11; PC already holds PC+4. -> FETCH.
- EXE_I(10): alu_src_a=1, alu_src_b=10. Per opcode:
  - ori: ext_op=00, alu_ctr=10.
  - lui: ext_op=10, alu_ctr=10 (A=rs expected $0).
  - addi: ext_op=01, alu_ctr=11.
  - -> IWB.
- IWB(11): holds EXE_I ALU controls; reg_dst=00, mem_to_reg=00. reg_wr=1, except addi with overflow=1 gives reg_wr=0 (write suppressed, no trap). -> FETCH.
- States 12-15 are unreachable; if entered, go to FETCH with all outputs 0.
- Cycle counts: beq/j/jal 3, R-type/I-ALU/sw 4, lw 5.
- rst asserted mid-instruction: immediate return to FETCH. No partial write may occur after the asynchronous assertion.

Test Plan:
- Reset then addu (op=0, funct=100001) -> states 0,1,6,7,0. reg_wr=1 only in state 7 with reg_dst=01, mem_to_reg=00, alu_ctr=00.
- lw (op=100011) -> states 0,1,2,3,4 (5 cycles). alu_ctr=00 and ext_op=01 in state 2. reg_wr=1, mem_to_reg=01 in state 4. sw -> mem_wr=1 for exactly one cycle in state 5.
- beq with zero=1 -> pc_wr=1, pc_src=01 in state 8. Repeat with zero=0 -> pc_wr=0. Both runs take 3 cycles.
- addi with overflow=0 -> reg_wr=1 in state 11. With overflow=1 -> reg_wr=0 in state 11. alu_ctr=11 throughout states 10-11.
- slt -> alu_ctr=01, mem_to_reg=10 in state 7. jal -> reg_dst=10, mem_to_reg=11, pc_src=10, pc_wr=1 in state 9.
- op=111111 -> illegal=1 for one cycle in DECODE, next state FETCH. rst pulsed in state 3 -> state=0 asynchronously, reg_wr never asserted.

Source files
------------

// File: rtl/mc_control.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Moore outputs decoded from the state register and the IR op/funct fields.
module mc_control #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       pc_wr,
  output logic [1:0] pc_src,
  output logic       ir_wr,
  output logic       mem_wr,
  output logic       reg_wr,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] ext_op,
  output logic [1:0] alu_ctr,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXE_R  = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_EXE_I  = 4'd10,
    S_IWB    = 4'd11
  } state_t;

  state_t state_q, state_d;

  logic is_r, r_addu, r_subu, r_slt, r_ok;
  logic is_ori, is_lui, is_addi, is_lw, is_sw;
  logic is_beq, is_j, is_jal;

  assign is_r    = (op == 6'b000000);
  assign r_addu  = is_r && (funct == 6'b100001);
  assign r_subu  = is_r && (funct == 6'b100011);
  assign r_slt   = is_r && (funct == 6'b101010);
  assign r_ok    = r_addu || r_subu || r_slt;
  assign is_ori  = (op == 6'b001101);
  assign is_lui  = (op == 6'b001111);
  assign is_addi = (op == 6'b001000);
  assign is_lw   = (op == 6'b100011);
  assign is_sw   = (op == 6'b101011);
  assign is_beq  = (op == 6'b000100);
  assign is_j    = (op == 6'b000010);
  assign is_jal  = (op == 6'b000011);

  assign state = state_q;

  // State register; async reset lands in FETCH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= state_t'(RESET_STATE);
    else     state_q <= state_d;
  end

  // Next-state and Moore output decode; all outputs forced low during reset
  always_comb begin
    state_d    = S_FETCH;
    pc_wr      = 1'b0;
    pc_src     = 2'b00;
    ir_wr      = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    ext_op     = 2'b00;
    alu_ctr    = 2'b00;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_wr     = 1'b1;
        pc_wr     = 1'b1;
        alu_src_b = 2'b01;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        ext_op    = 2'b01;
        unique case (1'b1)
          is_lw, is_sw:             state_d = S_MEMADR;
          r_ok:                     state_d = S_EXE_R;
          is_ori, is_lui, is_addi:  state_d = S_EXE_I;
          is_beq:                   state_d = S_BRANCH;
          is_j, is_jal:             state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_op    = 2'b01;
        state_d   = is_sw ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: state_d = S_MEMWB;
      S_MEMWB: begin
        reg_wr     = 1'b1;
        mem_to_reg = 2'b01;
      end
      S_MEMWR: begin
        mem_wr    = 1'b1;
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_op    = 2'b01;
      end
      S_EXE_R: begin
        alu_src_a = 1'b1;
        alu_ctr   = r_addu ? 2'b00 : 2'b01;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        alu_src_a  = 1'b1;
        alu_ctr    = r_addu ? 2'b00 : 2'b01;
        reg_wr     = 1'b1;
        reg_dst    = 2'b01;
        mem_to_reg = r_slt ? 2'b10 : 2'b00;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctr   = 2'b01;
        pc_src    = 2'b01;
        pc_wr     = zero;
      end
      S_JUMP: begin
        pc_wr  = 1'b1;
        pc_src = 2'b10;
        if (is_jal) begin
          reg_wr     = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b11;
        end
      end
      S_EXE_I, S_IWB: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        unique case (1'b1)
          is_ori: begin
            ext_op  = 2'b00;
            alu_ctr = 2'b10;
          end
          is_lui: begin
            ext_op  = 2'b10;
            alu_ctr = 2'b10;
          end
          default: begin
            ext_op  = 2'b01;
            alu_ctr = 2'b11;
          end
        endcase
        if (state_q == S_EXE_I) begin
          state_d = S_IWB;
        end else begin
          reg_wr = !(is_addi && overflow);
        end
      end
      default: state_d = S_FETCH;
    endcase
    if (rst) begin
      pc_wr      = 1'b0;
      pc_src     = 2'b00;
      ir_wr      = 1'b0;
      mem_wr     = 1'b0;
      reg_wr     = 1'b0;
      reg_dst    = 2'b00;
      mem_to_reg = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      ext_op     = 2'b00;
      alu_ctr    = 2'b00;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed testbench for mc_control.
// Walks each instruction class state by state and checks outputs.
module tb_mc_control;

  logic       clk, rst;
  logic [5:0] op, funct;
  logic       zero, overflow;
  logic       pc_wr, ir_wr, mem_wr, reg_wr;
  logic       alu_src_a, illegal;
  logic [1:0] pc_src, reg_dst, mem_to_reg;
  logic [1:0] alu_src_b, ext_op, alu_ctr;
  logic [3:0] state;

  int n_chk = 0;
  int n_fail = 0;

  mc_control dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct),
    .zero(zero), .overflow(overflow),
    .pc_wr(pc_wr), .pc_src(pc_src), .ir_wr(ir_wr),
    .mem_wr(mem_wr), .reg_wr(reg_wr), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ext_op(ext_op),
    .alu_ctr(alu_ctr), .illegal(illegal), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    op = 6'd0; funct = 6'd0; zero = 1'b0; overflow = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (state !== 4'd0) begin
      n_fail++; $display("FAIL rst_state got %0d exp 0", state);
    end
    n_chk++;
    if ({ir_wr, pc_wr, reg_wr, mem_wr} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_enables got %b exp 0000",
               {ir_wr, pc_wr, reg_wr, mem_wr});
    end
    rst = 1'b0;
    #1;
    n_chk++;
    if ({ir_wr, pc_wr, alu_src_b, pc_src, alu_ctr} !== 8'b11_01_00_00) begin
      n_fail++;
      $display("FAIL fetch_outs got %b exp 11010000",
               {ir_wr, pc_wr, alu_src_b, pc_src, alu_ctr});
    end
  endtask

  task automatic test_addu();
    int s[4] = '{0, 1, 6, 7};
    logic w[4] = '{0, 0, 0, 1};
    op = 6'b000000; funct = 6'b100001;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (state !== s[i][3:0] || reg_wr !== w[i]) begin
        n_fail++;
        $display("FAIL addu[%0d] state/reg_wr got %0d/%b exp %0d/%b",
                 i, state, reg_wr, s[i], w[i]);
      end
      if (i == 3) begin
        n_chk++;
        if ({reg_dst, mem_to_reg, alu_ctr} !== 6'b01_00_00) begin
          n_fail++;
          $display("FAIL addu_wb got %b exp 010000",
                   {reg_dst, mem_to_reg, alu_ctr});
        end
      end
      @(negedge clk);
    end
    n_chk++;
    if (state !== 4'd0) begin
      n_fail++; $display("FAIL addu_end state got %0d exp 0", state);
    end
  endtask

  task automatic test_lw();
    int s[5] = '{0, 1, 2, 3, 4};
    op = 6'b100011; funct = 6'd0;
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (state !== s[i][3:0]) begin
        n_fail++;
        $display("FAIL lw_state[%0d] got %0d exp %0d", i, state, s[i]);
      end
      if (i == 2) begin
        n_chk++;
        if ({alu_ctr, ext_op, alu_src_a, alu_src_b} !== 7'b00_01_1_10) begin
          n_fail++;
          $display("FAIL lw_memadr got %b exp 0001110",
                   {alu_ctr, ext_op, alu_src_a, alu_src_b});
        end
      end
      if (i == 4) begin
        n_chk++;
        if ({reg_wr, reg_dst, mem_to_reg} !== 5'b1_00_01) begin
          n_fail++;
          $display("FAIL lw_wb got %b exp 10001",
                   {reg_wr, reg_dst, mem_to_reg});
        end
      end
      @(negedge clk);
    end
    n_chk++;
    if (state !== 4'd0) begin
      n_fail++; $display("FAIL lw_end state got %0d exp 0", state);
    end
  endtask

  task automatic test_sw();
    int s[4] = '{0, 1, 2, 5};
    logic m[4] = '{0, 0, 0, 1};
    op = 6'b101011;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (state !== s[i][3:0] || mem_wr !== m[i] || reg_wr !== 1'b0) begin
        n_fail++;
        $display("FAIL sw[%0d] state/mem_wr/reg_wr got %0d/%b/%b exp %0d/%b/0",
                 i, state, mem_wr, reg_wr, s[i], m[i]);
      end
      @(negedge clk);
    end
    n_chk++;
    if (state !== 4'd0 || mem_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_end state/mem_wr got %0d/%b exp 0/0", state, mem_wr);
    end
  endtask

  task automatic test_beq(input logic z);
    int s[3] = '{0, 1, 8};
    op = 6'b000100; zero = z;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (state !== s[i][3:0]) begin
        n_fail++;
        $display("FAIL beq%0d_state[%0d] got %0d exp %0d", z, i, state, s[i]);
      end
      if (i == 2) begin
        n_chk++;
        if ({pc_wr, pc_src, alu_ctr, alu_src_a} !== {z, 2'b01, 2'b01, 1'b1}) begin
          n_fail++;
          $display("FAIL beq%0d_br got %b exp %b", z,
                   {pc_wr, pc_src, alu_ctr, alu_src_a}, {z, 5'b01011});
        end
      end
      @(negedge clk);
    end
    n_chk++;
    if (state !== 4'd0) begin
      n_fail++; $display("FAIL beq%0d_end state got %0d exp 0", z, state);
    end
    zero = 1'b0;
  endtask

  task automatic test_addi(input logic ov);
    int s[4] = '{0, 1, 10, 11};
    op = 6'b001000; overflow = ov;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (state !== s[i][3:0]) begin
        n_fail++;
        $display("FAIL addi%0d_state[%0d] got %0d exp %0d", ov, i, state, s[i]);
      end
      if (i >= 2) begin
        n_chk++;
        if ({alu_ctr, ext_op, alu_src_b} !== 6'b11_01_10) begin
          n_fail++;
          $display("FAIL addi%0d_alu[%0d] got %b exp 110110", ov, i,
                   {alu_ctr, ext_op, alu_src_b});
        end
      end
      if (i == 3) begin
        n_chk++;
        if (reg_wr !== !ov) begin
          n_fail++;
          $display("FAIL addi%0d_reg_wr got %b exp %b", ov, reg_wr, !ov);
        end
      end
      @(negedge clk);
    end
    overflow = 1'b0;
  endtask

  task automatic test_ori_lui();
    op = 6'b001101;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({state, ext_op, alu_ctr} !== {4'd10, 2'b00, 2'b10}) begin
      n_fail++;
      $display("FAIL ori_exe got %b exp 1010_00_10", {state, ext_op, alu_ctr});
    end
    repeat (2) @(negedge clk);
    op = 6'b001111;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({state, ext_op, alu_ctr, reg_wr} !== {4'd11, 2'b10, 2'b10, 1'b1}) begin
      n_fail++;
      $display("FAIL lui_iwb got %b exp 1011_10_10_1",
               {state, ext_op, alu_ctr, reg_wr});
    end
    @(negedge clk);
  endtask

  task automatic test_slt();
    op = 6'b000000; funct = 6'b101010;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({state, alu_ctr, mem_to_reg, reg_dst, reg_wr} !==
        {4'd7, 2'b01, 2'b10, 2'b01, 1'b1}) begin
      n_fail++;
      $display("FAIL slt_wb got %b exp 0111_01_10_01_1",
               {state, alu_ctr, mem_to_reg, reg_dst, reg_wr});
    end
    @(negedge clk);
  endtask

  task automatic test_jal();
    op = 6'b000011;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({state, pc_wr, pc_src, reg_wr, reg_dst, mem_to_reg} !==
        {4'd9, 1'b1, 2'b10, 1'b1, 2'b10, 2'b11}) begin
      n_fail++;
      $display("FAIL jal_jump got %b exp 1001_1_10_1_10_11",
               {state, pc_wr, pc_src, reg_wr, reg_dst, mem_to_reg});
    end
    @(negedge clk);
    n_chk++;
    if (state !== 4'd0) begin
      n_fail++; $display("FAIL jal_end state got %0d exp 0", state);
    end
  endtask

  task automatic test_illegal();
    op = 6'b111111;
    n_chk++;
    if (illegal !== 1'b0) begin
      n_fail++; $display("FAIL ill_fetch got %b exp 0", illegal);
    end
    @(negedge clk);
    n_chk++;
    if (state !== 4'd1 || illegal !== 1'b1) begin
      n_fail++;
      $display("FAIL ill_decode state/illegal got %0d/%b exp 1/1",
               state, illegal);
    end
    @(negedge clk);
    n_chk++;
    if (state !== 4'd0 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL ill_after state/illegal got %0d/%b exp 0/0",
               state, illegal);
    end
    op = 6'b000000; funct = 6'b000000;
    @(negedge clk);
    n_chk++;
    if (illegal !== 1'b1) begin
      n_fail++; $display("FAIL ill_funct got %b exp 1", illegal);
    end
    @(negedge clk);
  endtask

  task automatic test_rst_mid();
    op = 6'b100011;
    repeat (3) @(negedge clk);
    n_chk++;
    if (state !== 4'd3) begin
      n_fail++; $display("FAIL rstmid_pre state got %0d exp 3", state);
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (state !== 4'd0 || reg_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async state/reg_wr got %0d/%b exp 0/0",
               state, reg_wr);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_chk++;
      if (state !== 4'd0 || reg_wr !== 1'b0 || pc_wr !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_hold[%0d] state/reg_wr/pc_wr got %0d/%b/%b exp 0/0/0",
                 i, state, reg_wr, pc_wr);
      end
    end
    rst = 1'b0;
    #1;
    n_chk++;
    if (state !== 4'd0 || ir_wr !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_rel state/ir_wr got %0d/%b exp 0/1", state, ir_wr);
    end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw();
    test_sw();
    test_beq(1'b1);
    test_beq(1'b0);
    test_addi(1'b0);
    test_addi(1'b1);
    test_ori_lui();
    test_slt();
    test_jal();
    test_illegal();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
